// File: rtl/hex_display_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hex_display_pkg
// Purpose : Shared definitions for the hex display controller: FSM state
//           encoding, active-low seven-segment codes, scratch widths and the
//           double-dabble nibble adjust helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package hex_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  localparam int BCD_W     = 12;
  localparam int BIN_W     = 8;
  localparam int SCRATCH_W = BCD_W + BIN_W;

  // Active-low segment codes, bit7 = decimal point (kept off).
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Add 3 to every BCD nibble that is 5 or more, so that the following
  // left shift carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_encode.sv
`default_nettype none
// ============================================================================
// Module  : seg7_encode
// Purpose : Combinational BCD digit to active-low seven-segment decoder.
//           Non-decimal inputs (10-15) produce a blank digit.
// Ports   : bcd [3:0] in  - BCD digit
//           seg [7:0] out - active-low segments, bit7 = DP (always off)
// Revision: 1.0 - initial release
// ============================================================================
module seg7_encode
  import hex_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/hex_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hex_display_ctrl
// Purpose : Converts an 8-bit binary value to three decimal digits with a
//           sequential double-dabble (8 shift cycles) and drives three
//           active-low seven-segment displays, with optional leading-zero
//           blanking and a free-running blink.
// Ports   : clk            in  - system clock (rising edge)
//           reset_n        in  - asynchronous active-low reset
//           in_valid       in  - value offered
//           in_ready       out - value accepted this cycle (IDLE only)
//           in_value [7:0] in  - binary value 0-255
//           blank_lz       in  - blank leading zeros (sampled in LATCH)
//           blink_en       in  - blink all digits
//           done           out - one-cycle pulse when new digits appear
//           HEX0..HEX2     out - ones / tens / hundreds segments
// Revision: 1.0 - initial release
// ============================================================================
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int BLINK_DIV = 25000000
)(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_value,
  input  logic       blank_lz,
  input  logic       blink_en,
  output logic       done,
  output logic [7:0] HEX0,
  output logic [7:0] HEX1,
  output logic [7:0] HEX2
);

  localparam int                 PRESC_W   = $clog2(BLINK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(BLINK_DIV - 1);

  state_t               state_q, state_d;
  logic [SCRATCH_W-1:0] scratch_q, scratch_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [7:0]           hex0_q, hex0_d, hex1_q, hex1_d, hex2_q, hex2_d;
  logic                 done_q, done_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic                 phase_on_q, phase_on_d;

  logic                 load, shift_en, latch_en;
  logic [SCRATCH_W-1:0] adjusted;
  logic [7:0]           seg_ones, seg_tens, seg_hund;
  logic                 hund_zero, tens_zero, blank_all;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == 3'd0) state_d = ST_LATCH;  // 8th shift happening now
      ST_LATCH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready = 1'b0;
    load     = 1'b0;
    shift_en = 1'b0;
    latch_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        load     = in_valid;
      end
      ST_SHIFT: shift_en = 1'b1;
      ST_LATCH: latch_en = 1'b1;
      default:  ;
    endcase
  end

  // ---------------- Digit decoders ----------------
  seg7_encode u_seg_ones (.bcd(scratch_q[11:8]),  .seg(seg_ones));
  seg7_encode u_seg_tens (.bcd(scratch_q[15:12]), .seg(seg_tens));
  seg7_encode u_seg_hund (.bcd(scratch_q[19:16]), .seg(seg_hund));

  assign hund_zero = (scratch_q[19:16] == 4'd0);
  assign tens_zero = (scratch_q[15:12] == 4'd0);
  assign adjusted  = {bcd_adjust(scratch_q[SCRATCH_W-1:BIN_W]), scratch_q[BIN_W-1:0]};

  // ---------------- Datapath next state ----------------
  always_comb begin
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    hex0_d    = hex0_q;
    hex1_d    = hex1_q;
    hex2_d    = hex2_q;
    done_d    = latch_en;
    if (load) begin
      scratch_d = {{BCD_W{1'b0}}, in_value};
      cnt_d     = 3'd7;
    end else if (shift_en) begin
      scratch_d = adjusted << 1;
      // Holds at zero once the last shift is done.
      if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
    end
    if (latch_en) begin
      hex0_d = seg_ones;
      hex1_d = (blank_lz && hund_zero && tens_zero) ? SEG_BLANK : seg_tens;
      hex2_d = (blank_lz && hund_zero) ? SEG_BLANK : seg_hund;
    end
  end

  // ---------------- Blink prescaler (free running) ----------------
  always_comb begin
    if (presc_q == PRESC_MAX) begin
      presc_d    = '0;
      phase_on_d = ~phase_on_q;
    end else begin
      presc_d    = presc_q + PRESC_W'(1);
      phase_on_d = phase_on_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scratch_q  <= '0;
      cnt_q      <= '0;
      hex0_q     <= SEG_BLANK;
      hex1_q     <= SEG_BLANK;
      hex2_q     <= SEG_BLANK;
      done_q     <= 1'b0;
      presc_q    <= '0;
      phase_on_q <= 1'b1;
    end else begin
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      hex0_q     <= hex0_d;
      hex1_q     <= hex1_d;
      hex2_q     <= hex2_d;
      done_q     <= done_d;
      presc_q    <= presc_d;
      phase_on_q <= phase_on_d;
    end
  end

  // blink_en acts directly on the output mux, not through a register.
  assign blank_all = blink_en & ~phase_on_q;
  assign HEX0      = blank_all ? SEG_BLANK : hex0_q;
  assign HEX1      = blank_all ? SEG_BLANK : hex1_q;
  assign HEX2      = blank_all ? SEG_BLANK : hex2_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_hex_display_ctrl
// Purpose : Self-checking bench for hex_display_ctrl (BLINK_DIV = 4).
//           Expected digit triples are queued when a value is offered and
//           compared when done pulses.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hex_display_ctrl;

  localparam int BLINK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_value = 8'd0;
  logic       blank_lz = 1'b0;
  logic       blink_en = 1'b0;
  logic       done;
  logic [7:0] HEX0, HEX1, HEX2;

  hex_display_ctrl #(.BLINK_DIV(BLINK_DIV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_value (in_value),
    .blank_lz (blank_lz),
    .blink_en (blink_en),
    .done     (done),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] h2;
    logic [7:0] h1;
    logic [7:0] h0;
  } exp_t;

  typedef struct {
    logic [7:0] value;
    logic       blz;
    logic [7:0] h2;
    logic [7:0] h1;
    logic [7:0] h0;
  } vec_t;

  exp_t exp_q[$];
  vec_t vt[10];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  logic prev_done = 1'b0;
  int   ecount;

  // Edges seen since the last reset release: reference for the blink phase.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ecount <= 0;
    else          ecount <= ecount + 1;
  end

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic exp_t model(input logic [7:0] v, input logic blz);
    exp_t m;
    int h, t, o;
    h = int'(v) / 100;
    t = (int'(v) / 10) % 10;
    o = int'(v) % 10;
    m.h2 = (blz && h == 0) ? 8'hFF : seg_of(h);
    m.h1 = (blz && h == 0 && t == 0) ? 8'hFF : seg_of(t);
    m.h0 = seg_of(o);
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest pending entry.
  always @(negedge clk) begin : mon
    exp_t e;
    if (done === 1'b1) begin
      done_cnt++;
      check("done_single_cycle", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: HEX2..0=%h %h %h with nothing pending", HEX2, HEX1, HEX0);
      end else begin
        e = exp_q.pop_front();
        check("sb_hex2", {24'd0, HEX2}, {24'd0, e.h2});
        check("sb_hex1", {24'd0, HEX1}, {24'd0, e.h1});
        check("sb_hex0", {24'd0, HEX0}, {24'd0, e.h0});
      end
    end
    prev_done = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int g;
    g = 0;
    while (in_ready !== 1'b1 && g < 40) begin
      tick();
      g++;
    end
    if (in_ready !== 1'b1) check("ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic offer(input logic [7:0] v, input logic blz, input exp_t e);
    wait_ready();
    in_valid = 1'b1;
    in_value = v;
    blank_lz = blz;
    exp_q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 60) begin
      tick();
      g++;
    end
    check("drain_timeout", exp_q.size(), 32'd0);
    tick();
  endtask

  task automatic check_hex(input string name, input logic [7:0] h2, input logic [7:0] h1,
                           input logic [7:0] h0);
    check({name, "_hex2"}, {24'd0, HEX2}, {24'd0, h2});
    check({name, "_hex1"}, {24'd0, HEX1}, {24'd0, h1});
    check({name, "_hex0"}, {24'd0, HEX0}, {24'd0, h0});
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int   lows;
    int   d0;
    logic phase_on;
    exp_t e12;

    vt[0] = '{8'd255, 1'b0, 8'hA4, 8'h92, 8'h92};
    vt[1] = '{8'd7,   1'b1, 8'hFF, 8'hFF, 8'hF8};
    vt[2] = '{8'd0,   1'b1, 8'hFF, 8'hFF, 8'hC0};
    vt[3] = '{8'd100, 1'b1, 8'hF9, 8'hC0, 8'hC0};
    vt[4] = '{8'd42,  1'b1, 8'hFF, 8'h99, 8'hA4};
    vt[5] = '{8'd9,   1'b0, 8'hC0, 8'hC0, 8'h90};
    vt[6] = '{8'd10,  1'b1, 8'hFF, 8'hF9, 8'hC0};
    vt[7] = '{8'd205, 1'b1, 8'hA4, 8'hC0, 8'h92};
    vt[8] = '{8'd58,  1'b0, 8'hC0, 8'h92, 8'h80};
    vt[9] = '{8'd136, 1'b1, 8'hF9, 8'hB0, 8'h82};

    // Reset state
    #12;
    check_hex("reset", 8'hFF, 8'hFF, 8'hFF);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // 255 accepted on the first edge after reset release; latency and busy time
    d0 = done_cnt;
    in_valid = 1'b1;
    in_value = 8'd255;
    blank_lz = 1'b0;
    exp_q.push_back(model(8'd255, 1'b0));
    tick();
    in_valid = 1'b0;
    check("busy_after_accept", {31'd0, in_ready}, 32'd0);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      lows++;
      if (lows == 9) check("latency_early_hex0", {24'd0, HEX0}, 32'hFF);
    end
    check("in_ready_low_cycles", lows, 32'd9);
    drain();
    repeat (4) tick();
    check("done_pulses_255", done_cnt - d0, 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      offer(vt[i].value, vt[i].blz, '{vt[i].h2, vt[i].h1, vt[i].h0});
      drain();
    end

    // in_valid held with changing in_value while busy
    wait_ready();
    in_valid = 1'b1;
    in_value = 8'd37;
    blank_lz = 1'b0;
    exp_q.push_back(model(8'd37, 1'b0));
    tick();
    for (int k = 0; k < 9; k++) begin
      in_value = 8'($urandom_range(0, 255));
      tick();
    end
    in_valid = 1'b0;
    drain();
    repeat (12) tick();
    check_hex("hold_valid", 8'hC0, 8'hB0, 8'hF8);
    check("hold_valid_ready", {31'd0, in_ready}, 32'd1);

    // Reset during SHIFT aborts the conversion
    wait_ready();
    in_valid = 1'b1;
    in_value = 8'd200;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    check_hex("abort_reset", 8'hFF, 8'hFF, 8'hFF);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_done", {31'd0, done}, 32'd0);
    tick();
    reset_n = 1'b1;
    d0 = done_cnt;
    repeat (14) tick();
    check("abort_no_done", done_cnt - d0, 32'd0);
    check_hex("abort_idle", 8'hFF, 8'hFF, 8'hFF);

    // 42 offered together with reset release: taken on the first edge
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    in_valid = 1'b1;
    in_value = 8'd42;
    blank_lz = 1'b0;
    exp_q.push_back(model(8'd42, 1'b0));
    tick();
    in_valid = 1'b0;
    check("first_edge_accept", {31'd0, in_ready}, 32'd0);
    drain();

    // Blink: 12 shown, phase follows a 4-on/4-off cadence counted from reset
    e12 = model(8'd12, 1'b1);
    offer(8'd12, 1'b1, e12);
    drain();
    blink_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      phase_on = (((ecount / BLINK_DIV) % 2) == 0);
      if (phase_on) check_hex("blink_on", e12.h2, e12.h1, e12.h0);
      else          check_hex("blink_off", 8'hFF, 8'hFF, 8'hFF);
    end
    blink_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_hex("blink_dis", 8'hFF, 8'hF9, 8'hA4);
    end
    tick();

    // Exhaustive back-to-back sweep
    d0 = done_cnt;
    for (int v = 0; v < 256; v++) begin
      offer(8'(v), 1'b0, model(8'(v), 1'b0));
    end
    drain();
    repeat (4) tick();
    check("sweep_done_count", done_cnt - d0, 32'd256);
    check("sweep_queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
